bus_master_dma: RTL and testbench

//  Bus initiator (master) for the 3-master/8-slave shared bus: drives m_req/m_wr/m_address/m_dout, consumes m_grant/m_din.

---
 rtl/bus_pkg.sv | 8 +
 rtl/dma_buf.sv | 29 ++
 rtl/bus_master_dma.sv | 174 +++++++++++++++++
 tb/tb_bus_master_dma.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 3-master/8-slave bus and the masters that plug into it.
package bus_pkg;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 8;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, GAP, DONE} dma_state_t;
endpackage

// File: rtl/dma_buf.sv
// Chunk buffer for the DMA master: one synchronous write port, one asynchronous read port.
module dma_buf
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_master_dma.sv
// Bus master that copies a block of words in chunks of up to BURST words:
// read a chunk into the local buffer, write it out, then free the bus for one cycle.
module bus_master_dma
  import bus_pkg::*;
#(
  parameter int BURST      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_dout,
  input  logic              m_grant,
  input  logic [DATA_W-1:0] m_din
);

  localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int CW = $clog2(BURST) + 1;

  function automatic logic [CW-1:0] chunk_of(input logic [ADDR_W-1:0] rem);
    if (rem >= ADDR_W'(BURST)) return CW'(BURST);
    return rem[CW-1:0];
  endfunction

  dma_state_t state, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d;
  logic [CW-1:0]     chunk_q, chunk_d, rd_issue_q, rd_issue_d;
  logic [CW-1:0]     rd_cap_q, rd_cap_d, wr_idx_q, wr_idx_d;
  logic [RD_LATENCY-1:0] cap_sr;
  logic              rd_beat, wr_beat, cap_fire;
  logic              req_d, wr_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d, buf_rdata;

  assign rd_beat  = m_req & m_grant & (state == RD);
  assign wr_beat  = m_req & m_grant & (state == WR);
  assign cap_fire = cap_sr[RD_LATENCY-1];

  dma_buf #(.DEPTH(BURST), .IW(IW)) u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (cap_fire),
    .waddr (rd_cap_q[IW-1:0]),
    .wdata (m_din),
    .raddr (wr_idx_d[IW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d    = state;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    chunk_d    = chunk_q;
    rd_issue_d = rd_issue_q;
    wr_idx_d   = wr_idx_q;
    rd_cap_d   = rd_cap_q + CW'(cap_fire);
    case (state)
      IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          rem_d      = length;
          chunk_d    = chunk_of(length);
          rd_issue_d = '0;
          rd_cap_d   = '0;
          wr_idx_d   = '0;
          state_d    = (length != '0) ? RD : DONE;
        end
      end
      RD: begin
        if (rd_beat) begin
          rd_issue_d = rd_issue_q + CW'(1);
          if (rd_issue_d == chunk_q) state_d = RD_WAIT;
        end
      end
      // Registered rd_cap guarantees the whole chunk is in the buffer before the first write word is read out
      RD_WAIT: if (rd_cap_q == chunk_q) state_d = WR;
      WR: begin
        if (wr_beat) begin
          wr_idx_d = wr_idx_q + CW'(1);
          if (wr_idx_d == chunk_q) begin
            src_d   = src_q + ADDR_W'(chunk_q);
            dst_d   = dst_q + ADDR_W'(chunk_q);
            rem_d   = rem_q - ADDR_W'(chunk_q);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (rem_q != '0) begin
          chunk_d    = chunk_of(rem_q);
          rd_issue_d = '0;
          rd_cap_d   = '0;
          wr_idx_d   = '0;
          state_d    = RD;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they appear registered with it
  always_comb begin
    req_d  = 1'b0;
    wr_d   = 1'b0;
    addr_d = m_address;
    dout_d = '0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    case (state_d)
      RD: begin
        req_d  = 1'b1;
        addr_d = src_d + ADDR_W'(rd_issue_d);
      end
      RD_WAIT: req_d = 1'b1;
      WR: begin
        req_d  = 1'b1;
        wr_d   = 1'b1;
        addr_d = dst_d + ADDR_W'(wr_idx_d);
        dout_d = buf_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      chunk_q    <= '0;
      rd_issue_q <= '0;
      rd_cap_q   <= '0;
      wr_idx_q   <= '0;
      cap_sr     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_address  <= '0;
      m_dout     <= '0;
    end else begin
      state      <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      chunk_q    <= chunk_d;
      rd_issue_q <= rd_issue_d;
      rd_cap_q   <= rd_cap_d;
      wr_idx_q   <= wr_idx_d;
      cap_sr     <= RD_LATENCY'({cap_sr, rd_beat});
      busy       <= busy_d;
      done       <= done_d;
      m_req      <= req_d;
      m_wr       <= wr_d;
      m_address  <= addr_d;
      m_dout     <= dout_d;
    end
  end

endmodule

// File: tb/tb_bus_master_dma.sv
// Directed bench: DMA on master slot 0 of a memory-model bus, with a second master competing for grant.
module tb_bus_master_dma;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  src_addr, dst_addr, length;
  logic        busy, done, m_req, m_wr, m_grant;
  logic [7:0]  m_address;
  logic [31:0] m_dout, m_din;

  logic        grant_en, m1_req, m1_grant;
  logic [31:0] mem [256];
  logic [7:0]  rd_addr_q;
  logic [7:0]  rd_log[$];
  logic [7:0]  wr_log[$];
  int          checks, errors, done_cnt, gap_cnt, req_cnt, m1_gap_cnt;

  always #5 clk = ~clk;

  bus_master_dma dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .m_req     (m_req),
    .m_wr      (m_wr),
    .m_address (m_address),
    .m_dout    (m_dout),
    .m_grant   (m_grant),
    .m_din     (m_din)
  );

  // Fixed priority: DMA (slot 0) first, m1 gets the bus whenever the DMA does not hold it.
  assign m_grant  = m_req & grant_en;
  assign m1_grant = m1_req & ~m_grant;
  assign m_din    = mem[rd_addr_q];

  always @(posedge clk) begin
    if (m_req && m_grant && !m_wr) begin
      rd_addr_q <= m_address;
      if (rd_log.size() == 0 || rd_log[rd_log.size()-1] != m_address) rd_log.push_back(m_address);
    end
    if (m_req && m_grant && m_wr) begin
      mem[m_address] = m_dout;
      wr_log.push_back(m_address);
    end
    if (done) done_cnt++;
    if (busy && !m_req && !done) gap_cnt++;
    if (m_req) req_cnt++;
    if (busy && !done && m1_grant) m1_gap_cnt++;
  end

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'h5A, a, 8'hC3, ~a};
  endfunction

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    done_cnt = 0; gap_cnt = 0; req_cnt = 0; m1_gap_cnt = 0;
  endtask

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: busy=%b required 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    grant_en = 1'b1; m1_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (m_req !== 1'b0)      begin errors++; $display("FAIL reset_req: got %b required 0", m_req); end
    checks++; if (m_wr !== 1'b0)       begin errors++; $display("FAIL reset_wr: got %b required 0", m_wr); end
    checks++; if (m_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h required 00", m_address); end
    checks++; if (m_dout !== 32'h0)    begin errors++; $display("FAIL reset_dout: got %h required 0", m_dout); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b required 0", m_req); end
  endtask

  task automatic test_zero_length();
    clear_logs();
    pulse_start(8'h33, 8'h44, 8'h00);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_pulse: got %b required 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_clear: got %b required 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_clear: got %b required 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (req_cnt != 0)  begin errors++; $display("FAIL zero_req: got %0d req cycles required 0", req_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_single_chunk();
    for (int i = 0; i < 4; i++) mem[8'(8'h40 + i)] = '0;
    clear_logs();
    pulse_start(8'h10, 8'h40, 8'd4);
    wait_idle("single", 100);
    checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL single_rd_cnt: got %0d required 4", rd_log.size()); end
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL single_wr_cnt: got %0d required 4", wr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea, sa;
      sa = 8'(8'h10 + i); ea = 8'(8'h40 + i);
      checks++;
      if (i >= rd_log.size() || rd_log[i] !== sa) begin errors++; $display("FAIL single_rd_addr%0d: required %h", i, sa); end
      checks++;
      if (i >= wr_log.size() || wr_log[i] !== ea) begin errors++; $display("FAIL single_wr_addr%0d: required %h", i, ea); end
      checks++;
      if (mem[ea] !== pat(sa)) begin errors++; $display("FAIL single_data%0d: got %h required %h", i, mem[ea], pat(sa)); end
    end
    checks++; if (gap_cnt != 1)  begin errors++; $display("FAIL single_gap: got %0d required 1", gap_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_two_chunks();
    for (int i = 0; i < 6; i++) mem[8'(8'h60 + i)] = '0;
    clear_logs();
    m1_req = 1'b1;
    pulse_start(8'h20, 8'h60, 8'd6);
    wait_idle("two", 200);
    m1_req = 1'b0;
    checks++; if (rd_log.size() != 6) begin errors++; $display("FAIL two_rd_cnt: got %0d required 6", rd_log.size()); end
    checks++; if (wr_log.size() != 6) begin errors++; $display("FAIL two_wr_cnt: got %0d required 6", wr_log.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] ea, sa;
      sa = 8'(8'h20 + i); ea = 8'(8'h60 + i);
      checks++;
      if (i >= wr_log.size() || wr_log[i] !== ea) begin errors++; $display("FAIL two_wr_addr%0d: required %h", i, ea); end
      checks++;
      if (mem[ea] !== pat(sa)) begin errors++; $display("FAIL two_data%0d: got %h required %h", i, mem[ea], pat(sa)); end
    end
    checks++; if (gap_cnt != 2)    begin errors++; $display("FAIL two_gap: got %0d required 2", gap_cnt); end
    checks++; if (m1_gap_cnt < 1)  begin errors++; $display("FAIL two_m1_grant: got %0d required >=1", m1_gap_cnt); end
    checks++; if (done_cnt != 1)   begin errors++; $display("FAIL two_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_grant_stall();
    int n;
    for (int i = 0; i < 4; i++) mem[8'(8'h70 + i)] = '0;
    clear_logs();
    pulse_start(8'h30, 8'h70, 8'd4);
    n = 0;
    while (rd_log.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    grant_en = 1'b0;
    checks++; if (m_address !== 8'h32) begin errors++; $display("FAIL stall_rd_addr: got %h required 32", m_address); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_address !== 8'h32) begin errors++; $display("FAIL stall_rd_hold: got %h required 32", m_address); end
    grant_en = 1'b1;
    n = 0;
    while (wr_log.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    grant_en = 1'b0;
    checks++; if (m_address !== 8'h72) begin errors++; $display("FAIL stall_wr_addr: got %h required 72", m_address); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m_address !== 8'h72 || m_wr !== 1'b1) begin errors++; $display("FAIL stall_wr_hold: got %h wr=%b required 72 wr=1", m_address, m_wr); end
    grant_en = 1'b1;
    wait_idle("stall", 100);
    checks++; if (rd_log.size() != 4) begin errors++; $display("FAIL stall_rd_cnt: got %0d required 4", rd_log.size()); end
    checks++; if (wr_log.size() != 4) begin errors++; $display("FAIL stall_wr_cnt: got %0d required 4", wr_log.size()); end
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea, sa;
      sa = 8'(8'h30 + i); ea = 8'(8'h70 + i);
      checks++;
      if (mem[ea] !== pat(sa)) begin errors++; $display("FAIL stall_data%0d: got %h required %h", i, mem[ea], pat(sa)); end
    end
  endtask

  task automatic test_addr_wrap();
    for (int i = 0; i < 4; i++) mem[8'(8'h7E + i)] = '0;
    clear_logs();
    pulse_start(8'hFE, 8'h7E, 8'd4);
    wait_idle("wrap", 100);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea, sa;
      sa = 8'(8'hFE + i); ea = 8'(8'h7E + i);
      checks++;
      if (i >= rd_log.size() || rd_log[i] !== sa) begin errors++; $display("FAIL wrap_rd_addr%0d: required %h", i, sa); end
      checks++;
      if (i >= wr_log.size() || wr_log[i] !== ea) begin errors++; $display("FAIL wrap_wr_addr%0d: required %h", i, ea); end
      checks++;
      if (mem[ea] !== pat(sa)) begin errors++; $display("FAIL wrap_data%0d: got %h required %h", i, mem[ea], pat(sa)); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    for (int i = 0; i < 8; i++) mem[8'(8'h90 + i)] = '0;
    for (int i = 0; i < 3; i++) mem[8'(8'hA0 + i)] = '0;
    clear_logs();
    pulse_start(8'h50, 8'h90, 8'd8);
    n = 0;
    while (wr_log.size() < 5 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (m_wr !== 1'b1) begin errors++; $display("FAIL midrst_in_wr: got %b required 1", m_wr); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_req !== 1'b0)      begin errors++; $display("FAIL midrst_req: got %b required 0", m_req); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (m_address !== 8'h00) begin errors++; $display("FAIL midrst_addr: got %h required 00", m_address); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem[8'h96] !== 32'h0 || mem[8'h97] !== 32'h0) begin errors++; $display("FAIL midrst_no_more_wr: got %h %h required 0 0", mem[8'h96], mem[8'h97]); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_done: got %0d required 0", done_cnt); end
    clear_logs();
    pulse_start(8'h50, 8'hA0, 8'd3);
    wait_idle("after_rst", 100);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ea, sa;
      sa = 8'(8'h50 + i); ea = 8'(8'hA0 + i);
      checks++;
      if (mem[ea] !== pat(sa)) begin errors++; $display("FAIL after_rst_data%0d: got %h required %h", i, mem[ea], pat(sa)); end
    end
    checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL after_rst_wr_cnt: got %0d required 3", wr_log.size()); end
    checks++; if (done_cnt != 1)      begin errors++; $display("FAIL after_rst_done: got %0d required 1", done_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0;
    for (int a = 0; a < 256; a++) mem[a] = pat(8'(a));
    clear_logs();
    test_reset();
    test_zero_length();
    test_single_chunk();
    test_two_chunks();
    test_grant_stall();
    test_addr_wrap();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
